mult_issue_ctrl: RTL
====================

MULT_ISSUE_CTRL -- requirements
Module: mult_issue_ctrl

Interface
REQ-001 The parameter DATA_WIDTH SHALL default to 32 and set the operand/result width.
REQ-002 The parameter LATENCY SHALL default to 3 and give the downstream multiplier's start-to-done latency in cycles.
REQ-003 The parameter RD_WIDTH SHALL default to 5 and set the destination register tag width.
REQ-004 clk_i  in  1  single clock; all state on rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 req_valid_i / req_ready_o  in/out  1/1  execute-stage request handshake.
REQ-007 req_op_i  in  3  funct3 opcode: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
REQ-008 req_a_i, req_b_i  in  DATA_WIDTH  operands.
REQ-009 req_rd_i  in  RD_WIDTH  destination tag.
REQ-010 flush_i  in  1  kills any in-flight or pending operation.
REQ-011 mul_start_o  out  1  start pulse to the multiplier.
REQ-012 mul_op_o, mul_a_o, mul_b_o  out  3/DATA_WIDTH/DATA_WIDTH  operation and operands to the multiplier.
REQ-013 mul_result_i, mul_done_i  in  DATA_WIDTH/1  multiplier result and one-cycle done.
REQ-014 rsp_valid_o / rsp_ready_i  out/in  1/1  writeback handshake.
REQ-015 rsp_data_o, rsp_rd_o, rsp_err_o  out  DATA_WIDTH/RD_WIDTH/1  result, tag, error flag.
REQ-016 busy_o  out  1  high whenever the state is not IDLE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, WAIT, and RESP.
REQ-018 req_ready_o SHALL equal !flush_i && (IDLE || (RESP && rsp_ready_i)), so a new request can be accepted in the same cycle as a response handshake.
REQ-019 A request SHALL be accepted when req_valid_i && req_ready_o; on accept, req_rd_i SHALL be latched and the tag/error registers cleared.
REQ-020 For a legal op (req_op_i[2]==0), mul_start_o SHALL be high combinationally in the accept cycle, with mul_op_o/mul_a_o/mul_b_o driven straight from req_op_i/req_a_i/req_b_i, and the FSM SHALL go to WAIT.
REQ-021 mul_start_o SHALL be 0 in every other cycle; outside accept cycles, mul_op_o/mul_a_o/mul_b_o SHALL still pass through the request inputs.
REQ-022 For an illegal op (req_op_i[2]==1), the block SHALL accept the request, SHALL NOT pulse mul_start_o, and SHALL go to RESP with rsp_err_o=1 and rsp_data_o=0, so rsp_valid_o is high in the next cycle.
REQ-023 In WAIT, the watchdog counter SHALL read 1 in the first WAIT cycle and increment every cycle; its width SHALL be $clog2(LATENCY+3)+1.
REQ-024 In WAIT, when mul_done_i=1, mul_result_i SHALL be captured into rsp_data_o and the FSM SHALL go to RESP, so that with accept in cycle T, rsp_valid_o is high from cycle T+LATENCY+1.
REQ-025 In WAIT, if the counter equals LATENCY+2 and mul_done_i=0, the FSM SHALL go to RESP with rsp_err_o=1 and rsp_data_o=0.
REQ-026 In RESP, rsp_valid_o SHALL be 1, and rsp_data_o/rsp_rd_o/rsp_err_o SHALL stay stable until rsp_ready_i=1.
REQ-027 On a RESP handshake, the FSM SHALL go to IDLE, or to WAIT/RESP if a new request is accepted in the same cycle.
REQ-028 mul_done_i SHALL be ignored in IDLE and RESP.
REQ-029 flush_i SHALL have priority over everything else: in any state the FSM SHALL go to IDLE next cycle, rsp_valid_o SHALL drop, and no request SHALL be accepted in that cycle.
REQ-030 flush_i coincident with mul_done_i SHALL discard the result.
REQ-031 Because a new mul_start_o restarts the multiplier, a stale mul_done_i after a flush SHALL never produce a response.
REQ-032 rsp_valid_o SHALL be a registered state decode, never a combinational function of mul_done_i.

Reset
REQ-033 While rst_ni=0, the state SHALL be IDLE, and rsp_valid_o, rsp_err_o, mul_start_o and busy_o SHALL be 0.
REQ-034 While rst_ni=0, rsp_data_o, rsp_rd_o and the watchdog counter SHALL be 0, and req_ready_o SHALL be 1 when flush_i=0.
REQ-035 Assertion of rst_ni mid-operation SHALL abandon the operation with no response after release.

Verification
REQ-036 LATENCY=3, accept MUL 7*6 rd=5 in cycle 0 -> mul_start_o in cycle 0; rsp_valid_o in cycle 4 with data 42, rd 5, err 0.
REQ-037 MULH 0x80000000*0x80000000 -> rsp_data_o 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
REQ-038 Hold rsp_ready_i=0 for 5 cycles -> rsp outputs stable and req_ready_o=0; then raise rsp_ready_i with req_valid_i=1 -> back-to-back accept in the same cycle, with mul_start_o high.
REQ-039 Assert flush_i in the second WAIT cycle -> IDLE next cycle and no rsp_valid_o; a following MUL 3*3 -> response 9.
REQ-040 Tie mul_done_i=0 with accept in cycle 0 -> rsp_valid_o in cycle 6 with err 1, data 0; op 3'b100 -> err response in cycle 1 with no mul_start_o.
REQ-041 Pull rst_ni low during WAIT -> all outputs at reset values asynchronously; no response after release.

Source files
------------

// File: rtl/mult_issue_ctrl.sv
// Issue/writeback controller for a fixed-latency multiplier: accepts M-extension
// requests, starts the multiplier, guards it with a watchdog and holds the response.
module mult_issue_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LATENCY    = 3,
  parameter int unsigned RD_WIDTH   = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [2:0]            req_op_i,
  input  logic [DATA_WIDTH-1:0] req_a_i,
  input  logic [DATA_WIDTH-1:0] req_b_i,
  input  logic [RD_WIDTH-1:0]   req_rd_i,
  input  logic                  flush_i,
  output logic                  mul_start_o,
  output logic [2:0]            mul_op_o,
  output logic [DATA_WIDTH-1:0] mul_a_o,
  output logic [DATA_WIDTH-1:0] mul_b_o,
  input  logic [DATA_WIDTH-1:0] mul_result_i,
  input  logic                  mul_done_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic [RD_WIDTH-1:0]   rsp_rd_o,
  output logic                  rsp_err_o,
  output logic                  busy_o
);

  localparam int unsigned      CNT_W       = $clog2(LATENCY + 3) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(LATENCY + 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        wdog_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [RD_WIDTH-1:0]     rd_q;
  logic                    err_q;
  logic                    accept_s;
  logic                    illegal_s;

  assign illegal_s   = req_op_i[2];
  assign req_ready_o = !flush_i && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready_i));
  assign accept_s    = req_valid_i && req_ready_o;
  // Gated by reset so no start can leak to the multiplier while the block is held in reset.
  assign mul_start_o = rst_ni && accept_s && !illegal_s;
  assign mul_op_o    = req_op_i;
  assign mul_a_o     = req_a_i;
  assign mul_b_o     = req_b_i;

  assign rsp_valid_o = (state_q == RESP);
  assign busy_o      = (state_q != IDLE);
  assign rsp_data_o  = data_q;
  assign rsp_rd_o    = rd_q;
  assign rsp_err_o   = err_q;

  // Control FSM with watchdog and response holding registers; flush beats everything.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      wdog_q  <= '0;
      data_q  <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else if (flush_i) begin
      state_q <= IDLE;
      wdog_q  <= '0;
    end else if (accept_s) begin
      rd_q    <= req_rd_i;
      data_q  <= '0;
      err_q   <= illegal_s;
      wdog_q  <= CNT_ONE;
      state_q <= illegal_s ? RESP : WAIT;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= IDLE;
        end
        WAIT: begin
          if (mul_done_i) begin
            data_q  <= mul_result_i;
            state_q <= RESP;
          end else if (wdog_q == CNT_TIMEOUT) begin
            data_q  <= '0;
            err_q   <= 1'b1;
            state_q <= RESP;
          end else begin
            wdog_q  <= wdog_q + CNT_ONE;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_q <= IDLE;
          end else begin
            state_q <= RESP;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
